// File: rtl/mem_access_unit_if.sv
// Bundles the core request, memory command and response channels of mem_access_unit.
// master = the access unit itself, slave = the core/memory environment around it.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;

  logic                  mem_valid;
  logic                  mem_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_wstrb;
  logic [31:0]           mem_wdata;
  logic                  mem_rvalid;
  logic [31:0]           mem_rdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_we;
  logic                  rsp_err;
  logic [1:0]            rsp_size;
  logic [1:0]            rsp_offset;
  logic [31:0]           rsp_data;

  modport master (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready,
    output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output rsp_valid, rsp_we, rsp_err, rsp_size, rsp_offset, rsp_data,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready,
    input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  rsp_valid, rsp_we, rsp_err, rsp_size, rsp_offset, rsp_data,
    output rsp_ready
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store access unit: checks a core request, issues a single memory command
// and holds the raw (unaligned) response until the consumer accepts it.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int RSP_BUF    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.master io_bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT_R = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  function automatic logic f_is_err(input logic [1:0] size, input logic [1:0] off);
    logic err;
    case (size)
      2'b00:   err = 1'b0;
      2'b01:   err = off[0];
      2'b10:   err = (off != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [3:0] f_wstrb(input logic we, input logic [1:0] size,
                                         input logic [1:0] off);
    logic [3:0] strb;
    if (!we) begin
      strb = 4'b0000;
    end else begin
      case (size)
        2'b00:   strb = 4'b0001 << off;
        2'b01:   strb = 4'b0011 << off;
        2'b10:   strb = 4'b1111;
        default: strb = 4'b0000;
      endcase
    end
    return strb;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] lanes;
    case (size)
      2'b00:   lanes = {4{wdata[7:0]}};
      2'b01:   lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  state_t                r_state;
  state_t                w_next;
  logic                  w_req_ready;
  logic                  w_mem_valid;
  logic                  w_rsp_valid;
  logic                  w_accept;
  logic                  w_err;

  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [3:0]            r_mem_wstrb;
  logic [31:0]           r_mem_wdata;
  logic                  r_rsp_we;
  logic                  r_rsp_err;
  logic [1:0]            r_rsp_size;
  logic [1:0]            r_rsp_offset;
  logic [31:0]           r_rsp_data;

  assign w_accept = io_bus.req_valid & w_req_ready;
  assign w_err    = f_is_err(io_bus.req_size, io_bus.req_addr[1:0]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; read data in the mem_ready cycle is never sampled because WAIT_R is not yet entered
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_err ? S_RESP : S_ISSUE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (io_bus.mem_ready) begin
          w_next = r_mem_we ? S_RESP : S_WAIT_R;
        end else begin
          w_next = S_ISSUE;
        end
      end
      S_WAIT_R: begin
        if (io_bus.mem_rvalid) begin
          w_next = S_RESP;
        end else begin
          w_next = S_WAIT_R;
        end
      end
      S_RESP: begin
        if (io_bus.rsp_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_RESP;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    w_req_ready = 1'b0;
    w_mem_valid = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      S_IDLE:  w_req_ready = 1'b1;
      S_ISSUE: w_mem_valid = 1'b1;
      S_RESP:  w_rsp_valid = (RSP_BUF != 0);
      default: w_req_ready = 1'b0;
    endcase
  end

  // Command/response fields: captured once at accept and held, so they stay stable while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wstrb  <= 4'b0000;
      r_mem_wdata  <= 32'h0000_0000;
      r_rsp_we     <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_size   <= 2'b00;
      r_rsp_offset <= 2'b00;
      r_rsp_data   <= 32'h0000_0000;
    end else if (w_accept) begin
      r_mem_we     <= io_bus.req_we;
      r_mem_addr   <= {io_bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
      r_mem_wstrb  <= f_wstrb(io_bus.req_we, io_bus.req_size, io_bus.req_addr[1:0]);
      r_mem_wdata  <= f_wdata(io_bus.req_size, io_bus.req_wdata);
      r_rsp_we     <= io_bus.req_we;
      r_rsp_err    <= w_err;
      r_rsp_size   <= io_bus.req_size;
      r_rsp_offset <= io_bus.req_addr[1:0];
      r_rsp_data   <= 32'h0000_0000;
    end else if ((r_state == S_WAIT_R) && io_bus.mem_rvalid) begin
      r_rsp_data   <= io_bus.mem_rdata;
    end
  end

  assign io_bus.req_ready  = w_req_ready;
  assign io_bus.mem_valid  = w_mem_valid;
  assign io_bus.mem_we     = r_mem_we;
  assign io_bus.mem_addr   = r_mem_addr;
  assign io_bus.mem_wstrb  = r_mem_wstrb;
  assign io_bus.mem_wdata  = r_mem_wdata;
  assign io_bus.rsp_valid  = w_rsp_valid;
  assign io_bus.rsp_we     = r_rsp_we;
  assign io_bus.rsp_err    = r_rsp_err;
  assign io_bus.rsp_size   = r_rsp_size;
  assign io_bus.rsp_offset = r_rsp_offset;
  assign io_bus.rsp_data   = r_rsp_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit: vector table for single
// transactions plus hand-written stall, spurious-rvalid and mid-transaction reset sequences.
module tb_mem_access_unit;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  mem_access_unit_if #(.ADDR_WIDTH(32)) bus ();

  mem_access_unit #(.ADDR_WIDTH(32), .RSP_BUF(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic        err;
    logic [3:0]  wstrb;
    logic [31:0] mwdata;
    logic [31:0] maddr;
    int          cyc;
  } vec_t;

  vec_t vecs [11];
  vec_t post_rst_vec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    chk({tag, "_mem_valid"}, {31'd0, bus.mem_valid}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    chk({tag, "_rsp_err"},   {31'd0, bus.rsp_err},   32'd0);
    chk({tag, "_rsp_we"},    {31'd0, bus.rsp_we},    32'd0);
    chk({tag, "_mem_we"},    {31'd0, bus.mem_we},    32'd0);
    chk({tag, "_mem_wstrb"}, {28'd0, bus.mem_wstrb}, 32'd0);
    chk({tag, "_mem_addr"},  bus.mem_addr,  32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_rsp_data"},  bus.rsp_data,  32'd0);
  endtask

  // Runs one transaction from IDLE; acts as memory with mem_ready high and read latency v.lat.
  task automatic run_txn(input vec_t v);
    int cyc;
    int pend;
    bit done;
    bit seen_mem;
    chk("txn_req_ready", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = v.we;
    bus.req_size  = v.size;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.mem_ready = 1'b1;
    bus.rsp_ready = 1'b0;
    step();
    bus.req_valid = 1'b0;
    cyc = 1;
    pend = -1;
    done = 1'b0;
    seen_mem = 1'b0;
    while (!done && cyc <= 30) begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'hDEAD_BEEF;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = v.rdata;
          pend = -1;
        end
      end
      if (bus.mem_valid) begin
        if (!seen_mem) begin
          chk("mem_addr",  bus.mem_addr, v.maddr);
          chk("mem_we",    {31'd0, bus.mem_we}, {31'd0, v.we});
          chk("mem_wstrb", {28'd0, bus.mem_wstrb}, {28'd0, v.wstrb});
          if (v.we) chk("mem_wdata", bus.mem_wdata, v.mwdata);
        end
        seen_mem = 1'b1;
        pend = v.lat;
      end
      if (bus.rsp_valid) begin
        chk("latency",    cyc, v.cyc);
        chk("rsp_err",    {31'd0, bus.rsp_err}, {31'd0, v.err});
        chk("rsp_we",     {31'd0, bus.rsp_we},  {31'd0, v.we});
        chk("rsp_size",   {30'd0, bus.rsp_size}, {30'd0, v.size});
        chk("rsp_offset", {30'd0, bus.rsp_offset}, {30'd0, v.addr[1:0]});
        chk("rsp_data",   bus.rsp_data, (v.we || v.err) ? 32'd0 : v.rdata);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        done = 1'b1;
      end else begin
        step();
        cyc++;
      end
    end
    bus.mem_rvalid = 1'b0;
    chk("rsp_seen",      {31'd0, done}, 32'd1);
    chk("mem_valid_seen", {31'd0, seen_mem}, {31'd0, ~v.err});
    chk("rsp_released",  {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    //          we    size   addr         wdata        rdata        lat err   wstrb    mwdata       maddr        cyc
    vecs[0]  = '{1'b0, 2'b00, 32'h0000_1003, 32'h0000_0000, 32'hAABB_CCDD, 1, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_1000, 3};
    vecs[1]  = '{1'b1, 2'b01, 32'h0000_2002, 32'h0000_1234, 32'h0000_0000, 0, 1'b0, 4'b1100, 32'h1234_1234, 32'h0000_2000, 2};
    vecs[2]  = '{1'b0, 2'b10, 32'h0000_0006, 32'h0000_0000, 32'h1111_1111, 1, 1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0004, 1};
    vecs[3]  = '{1'b0, 2'b11, 32'h0000_0004, 32'h0000_0000, 32'h2222_2222, 1, 1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0004, 1};
    vecs[4]  = '{1'b1, 2'b00, 32'h0000_3001, 32'hFFFF_FFA5, 32'h0000_0000, 0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0000_3000, 2};
    vecs[5]  = '{1'b1, 2'b10, 32'h0000_4000, 32'hCAFE_F00D, 32'h0000_0000, 0, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0000_4000, 2};
    vecs[6]  = '{1'b0, 2'b10, 32'h0000_5004, 32'h0000_0000, 32'h1357_9BDF, 3, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_5004, 5};
    vecs[7]  = '{1'b0, 2'b01, 32'h0000_6001, 32'h0000_0000, 32'h3333_3333, 1, 1'b1, 4'b0000, 32'h0000_0000, 32'h0000_6000, 1};
    vecs[8]  = '{1'b0, 2'b01, 32'h0000_7002, 32'h0000_0000, 32'h0F0F_1234, 2, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_7000, 4};
    vecs[9]  = '{1'b1, 2'b00, 32'h0000_8003, 32'h0000_005A, 32'h0000_0000, 0, 1'b0, 4'b1000, 32'h5A5A_5A5A, 32'h0000_8000, 2};
    vecs[10] = '{1'b1, 2'b01, 32'h0000_9001, 32'h0000_BEEF, 32'h0000_0000, 0, 1'b1, 4'b0000, 32'h0000_0000, 32'h0000_9000, 1};
    post_rst_vec = '{1'b0, 2'b10, 32'h0000_C000, 32'h0000_0000, 32'h0BAD_F00D, 1, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_C000, 3};

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    bus.rsp_ready  = 1'b0;
    #2;
    chk_reset_outputs("rst_async");
    step();
    step();
    chk_reset_outputs("rst_held");

    // Release and present the first request immediately: accepted on the first rising edge.
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) run_txn(vecs[i]);

    // Stall: mem_ready low 5 cycles, rsp_ready low 3 cycles, second request held pending.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h0000_9000;
    bus.req_wdata = 32'h1122_3344;
    bus.mem_ready = 1'b0;
    bus.rsp_ready = 1'b0;
    step();
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b11;
    bus.req_addr  = 32'h0000_FFFF;
    bus.req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_mem_valid", {31'd0, bus.mem_valid}, 32'd1);
      chk("stall_mem_addr",  bus.mem_addr, 32'h0000_9000);
      chk("stall_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'h0000_000F);
      chk("stall_mem_wdata", bus.mem_wdata, 32'h1122_3344);
      chk("stall_mem_we",    {31'd0, bus.mem_we}, 32'd1);
      chk("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      step();
    end
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_rsp_valid",  {31'd0, bus.rsp_valid}, 32'd1);
      chk("hold_rsp_we",     {31'd0, bus.rsp_we}, 32'd1);
      chk("hold_rsp_err",    {31'd0, bus.rsp_err}, 32'd0);
      chk("hold_rsp_data",   bus.rsp_data, 32'd0);
      chk("hold_rsp_size",   {30'd0, bus.rsp_size}, 32'd2);
      chk("hold_rsp_offset", {30'd0, bus.rsp_offset}, 32'd0);
      chk("hold_req_ready",  {31'd0, bus.req_ready}, 32'd0);
      chk("hold_mem_valid",  {31'd0, bus.mem_valid}, 32'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("post_rsp_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("post_rsp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    step();
    bus.req_valid = 1'b0;
    chk("pending_err_valid",  {31'd0, bus.rsp_valid}, 32'd1);
    chk("pending_err_flag",   {31'd0, bus.rsp_err}, 32'd1);
    chk("pending_err_size",   {30'd0, bus.rsp_size}, 32'd3);
    chk("pending_err_offset", {30'd0, bus.rsp_offset}, 32'd3);
    chk("pending_err_mem",    {31'd0, bus.mem_valid}, 32'd0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    // Spurious mem_rvalid in IDLE, in ISSUE, and in the mem_ready cycle itself.
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h9999_9999;
    step();
    bus.mem_rvalid = 1'b0;
    chk("sp_idle_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("sp_idle_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("sp_idle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("sp_idle_rsp_data",  bus.rsp_data, 32'd0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h0000_A000;
    bus.mem_ready = 1'b0;
    step();
    bus.req_valid  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h6666_6666;
    step();
    bus.mem_rvalid = 1'b0;
    chk("sp_issue_mem_valid", {31'd0, bus.mem_valid}, 32'd1);
    chk("sp_issue_mem_addr",  bus.mem_addr, 32'h0000_A000);
    chk("sp_issue_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h7777_7777;
    step();
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    chk("sp_hs_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("sp_hs_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    step();
    chk("sp_wait_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h2468_ACE0;
    step();
    bus.mem_rvalid = 1'b0;
    chk("sp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("sp_rsp_data",  bus.rsp_data, 32'h2468_ACE0);
    chk("sp_rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    // Reset while waiting for read data abandons the transaction.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h0000_B000;
    bus.mem_ready = 1'b1;
    step();
    bus.req_valid = 1'b0;
    step();
    chk("wr_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("wr_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555_5555;
    step();
    bus.mem_rvalid = 1'b0;
    chk("late_rv_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("late_rv_rsp_data",  bus.rsp_data, 32'd0);
    chk("late_rv_req_ready", {31'd0, bus.req_ready}, 32'd1);
    step();
    chk("late_rv_rsp_valid2", {31'd0, bus.rsp_valid}, 32'd0);
    run_txn(post_rst_vec);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: ADDR_WIDTH, default 32, byte address width of requests and memory port.
REQ-002 Parameter: RSP_BUF, default 1, 1 = response held in an output register until accepted; 0 is not supported.
REQ-003 Ports, listed as name / direction / width / meaning:
- clk / in / 1 / single clock, rising edge.
- rst_n / in / 1 / asynchronous, active-low reset.
- req_valid / in / 1 / core request valid.
- req_ready / out / 1 / unit accepts a request.
- req_we / in / 1 / 1 = store, 0 = load.
- req_size / in / 2 / 00 byte, 01 half, 10 word, 11 reserved.
- req_addr / in / ADDR_WIDTH / byte address.
- req_wdata / in / 32 / store data, right-aligned.
- mem_valid / out / 1 / memory command valid.
- mem_ready / in / 1 / memory accepts the command.
- mem_we / out / 1 / command is a write.
- mem_addr / out / ADDR_WIDTH / word address with low 2 bits forced to 0.
- mem_wstrb / out / 4 / byte enables.
- mem_wdata / out / 32 / lane-replicated write data.
- mem_rvalid / in / 1 / read data valid, one cycle.
- mem_rdata / in / 32 / raw read word.
- rsp_valid / out / 1 / response valid.
- rsp_ready / in / 1 / consumer accepts the response.
- rsp_we / out / 1 / response is for a store.
- rsp_err / out / 1 / misaligned or reserved-size request.
- rsp_size / out / 2 / request size, passed on to the load aligner.
- rsp_offset / out / 2 / req_addr[1:0] of the request.
- rsp_data / out / 32 / raw memory word, unaligned; 0 for stores and errors.

Function
REQ-004 FSM states are IDLE, ISSUE, WAIT_R and RESP; the state is encoded in one register.
REQ-005 req_ready SHALL be 1 only in IDLE; a request is accepted on req_valid & req_ready, and all request fields are captured in that cycle.
REQ-006 Error check at accept:
- An error is size==11, size==01 with addr[0]=1, or size==10 with addr[1:0]!=0.
- On error the FSM goes IDLE->RESP with rsp_err=1, and no mem_valid is ever asserted.
REQ-007 A legal request goes IDLE->ISSUE; mem_valid=1 in ISSUE, and the command fields stay stable until mem_ready.
REQ-008 In ISSUE on mem_ready, a store goes to RESP and a load goes to WAIT_R.
REQ-009 In WAIT_R on mem_rvalid, mem_rdata is captured into rsp_data and the FSM goes to RESP; mem_rvalid arriving in the same cycle as mem_ready is ignored, since one-cycle-minimum read latency is guaranteed by the memory.
REQ-010 In RESP, rsp_valid=1 and all rsp_* fields stay stable; on rsp_ready the FSM goes to IDLE, and a new request is accepted one cycle later at the earliest.
REQ-011 mem_wstrb by size, with off = addr[1:0]:
- byte: 4'b0001<<off.
- half: 4'b0011<<off.
- word: 4'b1111.
- Loads drive mem_wstrb=0.
REQ-012 mem_wdata by size:
- byte: {4{wdata[7:0]}}.
- half: {2{wdata[15:0]}}.
- word: wdata.
REQ-013 At most one transaction is outstanding; requests arriving while not in IDLE are stalled with req_ready=0, not dropped.
REQ-014 Latency with mem_ready held high and read latency L:
- Load: rsp_valid L+2 cycles after accept.
- Store: rsp_valid 2 cycles after accept.
- Error: rsp_valid 1 cycle after accept.
REQ-015 A mem_rvalid outside WAIT_R is ignored and does not change state or outputs.
REQ-016 rsp_size and rsp_offset carry the captured request values unchanged, including on error.

Reset
REQ-017 While rst_n=0, independent of clk, all of the following hold:
- State is IDLE.
- Outputs are 0: mem_valid, rsp_valid, rsp_err, rsp_we, mem_we and mem_wstrb.
- mem_addr, mem_wdata and rsp_data are 0.
- req_ready is 1.
REQ-018 Reset asserted mid-transaction abandons that transaction, and no response is produced for it after reset release; the memory side is required to drop the command.
REQ-019 The first request is accepted on the first rising edge after rst_n is deasserted.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Byte load, addr=0x1003, mem_rdata=0xAABBCCDD, L=1 -> mem_addr=0x1000, wstrb=0; rsp_data=0xAABBCCDD, rsp_offset=3, rsp_size=00, err=0, three cycles after accept.
- Half store, addr=0x2002, wdata=0x1234 -> mem_wstrb=1100, mem_wdata=0x12341234, mem_we=1; store response with rsp_we=1, rsp_data=0.
- Word load, addr=0x0006 -> no mem_valid; rsp_err=1 one cycle after accept; size=11 behaves the same way.
- mem_ready held low 5 cycles, rsp_ready held low 3 cycles -> mem_* and rsp_* fields stable throughout; req_ready=0 until the rsp handshake.
- Spurious mem_rvalid while in IDLE and in ISSUE -> no state or output change.
- rst_n pulled low in WAIT_R -> immediate IDLE, outputs per REQ-017; a later mem_rvalid is ignored, and the next load completes normally.
